coord_sched_ctrl: RTL and testbench
===================================

Name: coord_sched_ctrl

Overview:
Sequencer for the sparse-convolution coordinate computation datapath.
- Walks the Cartesian product of compressed weight chunks × activation chunks for one tile.
- Issues one (weight chunk, activation chunk) pair per accepted handshake.
- Tells the datapath when to restart its running activation index.
- Waits for the datapath pipeline to drain, then signals completion.
- Sits between the PE tile controller (start/done) and the coordinate unit plus its index buffers.

Parameters:
CNT_W, 8, width of chunk counters/indices
DRAIN_CYC, 2, cycles waited after last issue before done (datapath latency)

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
start  in  1  pulse; begin tile (ignored unless IDLE)
bitwidth  in  4  precision mode, sampled at start: 1→16 lanes, 2→8 lanes, 3→4 lanes, other=illegal
num_w_chunks  in  CNT_W  weight chunks in tile, sampled at start
num_a_chunks  in  CNT_W  activation chunks in tile, sampled at start
issue_valid  out  1  pair presented to datapath
issue_ready  in  1  datapath accepts pair
issue_w_idx  out  CNT_W  weight chunk index
issue_a_idx  out  CNT_W  activation chunk index
issue_a_restart  out  1  high with issue when issue_a_idx==0 (datapath clears running activation index)
issue_lanes  out  5  active lanes per chunk (16/8/4)
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at tile completion
cfg_err  out  1  one-cycle pulse on illegal config

Behaviour:
- Reset (synchronous, reset_n low at clk edge): state IDLE; all outputs 0; counters 0; latched config 0.
- Reset mid-operation aborts the tile. No done is produced. The next start begins fresh.
- States: IDLE, CHECK, ISSUE, DRAIN, FIN.
- IDLE:
  - On start, latch bitwidth, num_w_chunks, num_a_chunks; go to CHECK.
  - A start while not IDLE is ignored.
- CHECK (1 cycle):
  - Illegal bitwidth: cfg_err=1 this cycle, go to IDLE.
  - Else if either count is 0: go to FIN (empty tile, no issues).
  - Else clear w_cnt and a_cnt, set issue_lanes, go to ISSUE.
- ISSUE:
  - issue_valid=1; issue_w_idx=w_cnt; issue_a_idx=a_cnt; issue_a_restart=(a_cnt==0).
  - Outputs stay stable while issue_ready=0 (valid is never withdrawn).
  - On valid&&ready:
    - a_cnt increments.
    - When a_cnt==num_a_chunks-1: a_cnt←0 and w_cnt increments.
    - When w_cnt==num_w_chunks-1 and a_cnt==num_a_chunks-1: go to DRAIN, with issue_valid=0 on the next cycle.
  - Order is weight-major: all activation chunks for w=0, then w=1, and so on.
  - Total issues = num_w_chunks*num_a_chunks.
- DRAIN: a down-counter loaded with DRAIN_CYC-1 counts to 0, then go to FIN. DRAIN_CYC=0 is treated as 1.
- FIN: done=1 for one cycle, go to IDLE. busy drops in the same cycle done rises' successor, i.e. busy=0 in IDLE.
- Counters never wrap: the maximum index is 2^CNT_W-1, bounded by the count inputs.
- issue_lanes holds its value until the next CHECK. In IDLE it reads as the last value (0 after reset).
- Throughput: one issue per cycle with issue_ready tied high.
- Latency for N pairs with ready high: start→first issue_valid = 2 cycles; start→done = N+2+DRAIN_CYC cycles.

Optional Feature:
COORD_SCHED_PERF_EN
- Defined:
  - Adds output perf_stall_cnt[31:0], counting ISSUE cycles with issue_valid&&!issue_ready.
  - Adds output perf_issue_cnt[31:0], counting accepted issues.
  - Both clear on start acceptance and on reset, saturate at all-ones, and hold after done.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package coord_pkg holds:
  - state enum coord_sched_state_t {IDLE,CHECK,ISSUE,DRAIN,FIN};
  - bitwidth mode constants BW_16LANE=1, BW_8LANE=2, BW_4LANE=3;
  - function lanes_for_bw(bitwidth) returning 16/8/4/0.
- One natural sub-module: coord_pair_counter (nested w/a counter with last-pair flag and advance enable). Used only here; the FSM stays in the top.

Test Plan:
- bitwidth=1, w=2, a=3, ready=1 → 6 issues with (w,a) order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); restart on 1st and 4th; lanes=16; done at cycle 6+2+2=10 after start.
- bitwidth=3, w=1, a=2; ready low for 3 cycles on 2nd pair → pair (0,1) held stable for 4 cycles; done after drain; perf_stall_cnt=3 with COORD_SCHED_PERF_EN.
- bitwidth=5 → cfg_err pulse in cycle 1 after start; no issue_valid; no done; busy high for exactly 1 cycle.
- num_a_chunks=0 → no issues; done pulse 2 cycles after start.
- reset_n low during ISSUE at pair (1,0) → next edge: all outputs 0, IDLE; a new start with w=1, a=1 gives issue (0,0) with restart=1.
- start re-pulsed during ISSUE → ignored; issue count is unchanged at w*a.

Source files
------------

// File: rtl/coord_pkg.sv
// Shared types and helpers for the sparse-convolution coordinate sequencer.
package coord_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        DRAIN,
        FIN
    } coord_sched_state_t;

    localparam logic [3:0] BW_16LANE = 4'd1;
    localparam logic [3:0] BW_8LANE  = 4'd2;
    localparam logic [3:0] BW_4LANE  = 4'd3;

    // Lanes per chunk for a precision mode; 0 marks an illegal mode.
    function automatic logic [4:0] lanes_for_bw(input logic [3:0] bitwidth);
        case (bitwidth)
            BW_16LANE: lanes_for_bw = 5'd16;
            BW_8LANE:  lanes_for_bw = 5'd8;
            BW_4LANE:  lanes_for_bw = 5'd4;
            default:   lanes_for_bw = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/coord_pair_counter.sv
// Nested weight/activation chunk counter. Activation index is the inner
// (fast) loop; the weight index advances when the activation index wraps.
// Neither index steps past its count, so no wrap at 2^CNT_W.
module coord_pair_counter
    import coord_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] num_w,
    input  logic [CNT_W-1:0] num_a,
    output logic [CNT_W-1:0] w_cnt,
    output logic [CNT_W-1:0] a_cnt,
    output logic             last_pair
);

    logic a_last;
    logic w_last;

    assign a_last    = (a_cnt == num_a - CNT_W'(1));
    assign w_last    = (w_cnt == num_w - CNT_W'(1));
    assign last_pair = a_last && w_last;

    // Step the pair in weight-major order on each accepted issue.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_cnt <= '0;
            a_cnt <= '0;
        end else if (clear) begin
            w_cnt <= '0;
            a_cnt <= '0;
        end else if (advance) begin
            if (a_last) begin
                a_cnt <= '0;
                if (!w_last) begin
                    w_cnt <= w_cnt + CNT_W'(1);
                end
            end else begin
                a_cnt <= a_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/coord_sched_ctrl.sv
// Coordinate sequencer: walks weight x activation chunk pairs for one tile,
// waits for the datapath to drain, then pulses done.
// Optional: COORD_SCHED_PERF_EN adds stall / accepted-issue counters.
//
// state | meaning
// IDLE  | waiting for start, config latched on start
// CHECK | validate config, prime counters and lane count
// ISSUE | present pair, advance on valid && ready
// DRAIN | down-count datapath latency after the last issue
// FIN   | one-cycle done pulse
module coord_sched_ctrl
    import coord_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       bitwidth,
    input  logic [CNT_W-1:0] num_w_chunks,
    input  logic [CNT_W-1:0] num_a_chunks,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [CNT_W-1:0] issue_w_idx,
    output logic [CNT_W-1:0] issue_a_idx,
    output logic             issue_a_restart,
    output logic [4:0]       issue_lanes,
`ifdef COORD_SCHED_PERF_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_issue_cnt,
`endif
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    // DRAIN_CYC of 0 behaves as 1: the drain state always lasts at least a cycle.
    localparam int DRAIN_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int DRAIN_LOAD_I = (DRAIN_CYC > 1) ? DRAIN_CYC - 1 : 0;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_LOAD_I);

    coord_sched_state_t state, state_nxt;

    logic [3:0]         bw_q;
    logic [CNT_W-1:0]   num_w_q;
    logic [CNT_W-1:0]   num_a_q;
    logic [4:0]         lanes_q;
    logic [DRAIN_W-1:0] drain_cnt;

    logic               clear_cnt;
    logic               load_lanes;
    logic               fire;
    logic               last_pair;
    logic               start_acc;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   a_cnt;

    assign start_acc = (state == IDLE) && start;
    assign fire      = (state == ISSUE) && issue_ready;

    coord_pair_counter #(
        .CNT_W (CNT_W)
    ) u_pair_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear_cnt),
        .advance   (fire),
        .num_w     (num_w_q),
        .num_a     (num_a_q),
        .w_cnt     (w_cnt),
        .a_cnt     (a_cnt),
        .last_pair (last_pair)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        state_nxt   = state;
        issue_valid = 1'b0;
        done        = 1'b0;
        cfg_err     = 1'b0;
        clear_cnt   = 1'b0;
        load_lanes  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (lanes_for_bw(bw_q) == 5'd0) begin
                    cfg_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (num_w_q == '0 || num_a_q == '0) begin
                    state_nxt = FIN;
                end else begin
                    clear_cnt  = 1'b1;
                    load_lanes = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready && last_pair) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign issue_w_idx     = issue_valid ? w_cnt : '0;
    assign issue_a_idx     = issue_valid ? a_cnt : '0;
    assign issue_a_restart = issue_valid && (a_cnt == '0);
    assign issue_lanes     = lanes_q;

    // Tile config latch, lane count and drain timer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bw_q      <= '0;
            num_w_q   <= '0;
            num_a_q   <= '0;
            lanes_q   <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_acc) begin
                bw_q    <= bitwidth;
                num_w_q <= num_w_chunks;
                num_a_q <= num_a_chunks;
            end
            if (load_lanes) begin
                lanes_q <= lanes_for_bw(bw_q);
            end
            if (fire && last_pair) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

`ifdef COORD_SCHED_PERF_EN
    // Saturating stall / accepted-issue counters, cleared per tile.
    always_ff @(posedge clk) begin
        if (!reset_n || start_acc) begin
            perf_stall_cnt <= '0;
            perf_issue_cnt <= '0;
        end else begin
            if (state == ISSUE && !issue_ready && !(&perf_stall_cnt)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (fire && !(&perf_issue_cnt)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coord_sched_ctrl.sv
// Scoreboard bench for coord_sched_ctrl: stimulus pushes expected issues,
// done cycles and cfg_err cycles; a negedge monitor pops and compares.
module tb_coord_sched_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] bitwidth;
    logic [7:0] num_w_chunks;
    logic [7:0] num_a_chunks;
    logic       issue_valid;
    logic       issue_ready;
    logic [7:0] issue_w_idx;
    logic [7:0] issue_a_idx;
    logic       issue_a_restart;
    logic [4:0] issue_lanes;
    logic       busy;
    logic       done;
    logic       cfg_err;
`ifdef COORD_SCHED_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_issue_cnt;
`endif

    coord_sched_ctrl #(
        .CNT_W     (8),
        .DRAIN_CYC (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .bitwidth        (bitwidth),
        .num_w_chunks    (num_w_chunks),
        .num_a_chunks    (num_a_chunks),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_w_idx     (issue_w_idx),
        .issue_a_idx     (issue_a_idx),
        .issue_a_restart (issue_a_restart),
        .issue_lanes     (issue_lanes),
`ifdef COORD_SCHED_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_issue_cnt  (perf_issue_cnt),
`endif
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int a;
        int r;
        int l;
    } exp_t;

    exp_t exp_q[$];
    int   exp_done[$];
    int   exp_cfg[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    bit   hold_prev = 1'b0;
    int   hold_w;
    int   hold_a;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_iss(int w, int a, int r, int l);
        exp_t e;
        e.w = w; e.a = a; e.r = r; e.l = l;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int bw, input int w, input int a);
        bitwidth     = 4'(bw);
        num_w_chunks = 8'(w);
        num_a_chunks = 8'(a);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    // Monitor: scoreboard pops and hold-stability checks.
    always @(negedge clk) begin
        exp_t e;
        if (hold_prev) begin
            checks++;
            if (!(issue_valid && int'(issue_w_idx) == hold_w && int'(issue_a_idx) == hold_a)) begin
                failures++;
                $display("FAIL hold_stable: got v=%0d (%0d,%0d) expected v=1 (%0d,%0d) cycle %0d",
                         issue_valid, issue_w_idx, issue_a_idx, hold_w, hold_a, cyc);
            end
        end
        hold_prev = issue_valid && !issue_ready;
        hold_w    = int'(issue_w_idx);
        hold_a    = int'(issue_a_idx);

        if (issue_valid && issue_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue: got (%0d,%0d) expected none cycle %0d",
                         issue_w_idx, issue_a_idx, cyc);
            end else begin
                e = exp_q.pop_front();
                if (int'(issue_w_idx) != e.w || int'(issue_a_idx) != e.a ||
                    int'(issue_a_restart) != e.r || int'(issue_lanes) != e.l) begin
                    failures++;
                    $display("FAIL issue: got w=%0d a=%0d r=%0d l=%0d expected w=%0d a=%0d r=%0d l=%0d cycle %0d",
                             issue_w_idx, issue_a_idx, issue_a_restart, issue_lanes,
                             e.w, e.a, e.r, e.l, cyc);
                end
            end
        end

        if (done) begin
            checks++;
            if (exp_done.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                int ec;
                ec = exp_done.pop_front();
                if (ec != cyc) begin
                    failures++;
                    $display("FAIL done_cycle: got %0d expected %0d", cyc, ec);
                end
            end
        end

        if (cfg_err) begin
            checks++;
            if (exp_cfg.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cfg_err: got cfg_err at cycle %0d expected none", cyc);
            end else begin
                int ec;
                ec = exp_cfg.pop_front();
                if (ec != cyc) begin
                    failures++;
                    $display("FAIL cfg_err_cycle: got %0d expected %0d", cyc, ec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        reset_n      = 1'b0;
        start        = 1'b0;
        bitwidth     = 4'd0;
        num_w_chunks = 8'd0;
        num_a_chunks = 8'd0;
        issue_ready  = 1'b0;
        repeat (3) tick();

        // Reset state.
        chk("rst_valid", int'(issue_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_lanes", int'(issue_lanes), 0);
        chk("rst_restart", int'(issue_a_restart), 0);
        reset_n = 1'b1;
        tick();

        // 2x3 tile, 16 lanes, ready tied high.
        issue_ready = 1'b1;
        s = cyc;
        push_iss(0, 0, 1, 16); push_iss(0, 1, 0, 16); push_iss(0, 2, 0, 16);
        push_iss(1, 0, 1, 16); push_iss(1, 1, 0, 16); push_iss(1, 2, 0, 16);
        exp_done.push_back(s + 10);
        pulse_start(1, 2, 3);
        chk("t1_busy_check", int'(busy), 1);
        chk("t1_no_valid_in_check", int'(issue_valid), 0);
        tick();
        chk("t1_first_valid", int'(issue_valid), 1);
        wait_idle();

        // 1x2 tile, 4 lanes, 3 stall cycles on the second pair.
        s = cyc;
        push_iss(0, 0, 1, 4); push_iss(0, 1, 0, 4);
        exp_done.push_back(s + 9);
        pulse_start(3, 1, 2);
        tick();
        tick();
        issue_ready = 1'b0;
        tick();
        chk("t2_held_w", int'(issue_w_idx), 0);
        chk("t2_held_a", int'(issue_a_idx), 1);
        tick();
        tick();
        issue_ready = 1'b1;
        wait_idle();
`ifdef COORD_SCHED_PERF_EN
        chk("t2_perf_stall", int'(perf_stall_cnt), 3);
        chk("t2_perf_issue", int'(perf_issue_cnt), 2);
`endif

        // Illegal bitwidth.
        s = cyc;
        exp_cfg.push_back(s + 1);
        pulse_start(5, 2, 2);
        chk("t3_busy_check", int'(busy), 1);
        tick();
        chk("t3_busy_after", int'(busy), 0);
        tick();
        chk("t3_busy_stays_low", int'(busy), 0);

        // Empty tile: zero activation chunks.
        s = cyc;
        exp_done.push_back(s + 2);
        pulse_start(2, 3, 0);
        wait_idle();
        chk("t4_lanes_hold", int'(issue_lanes), 4);

        // Reset while presenting pair (1,0).
        s = cyc;
        push_iss(0, 0, 1, 8); push_iss(0, 1, 0, 8); push_iss(1, 0, 1, 8);
        pulse_start(2, 2, 2);
        tick();
        tick();
        tick();
        chk("t5_at_pair_w", int'(issue_w_idx), 1);
        chk("t5_at_pair_a", int'(issue_a_idx), 0);
        reset_n = 1'b0;
        tick();
        chk("t5_rst_valid", int'(issue_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_lanes", int'(issue_lanes), 0);
        chk("t5_rst_w", int'(issue_w_idx), 0);
        chk("t5_rst_done", int'(done), 0);
        reset_n = 1'b1;
        tick();
        s = cyc;
        push_iss(0, 0, 1, 16);
        exp_done.push_back(s + 5);
        pulse_start(1, 1, 1);
        wait_idle();

        // Start re-pulsed during ISSUE with different config is ignored.
        s = cyc;
        push_iss(0, 0, 1, 16); push_iss(0, 1, 0, 16);
        push_iss(1, 0, 1, 16); push_iss(1, 1, 0, 16);
        exp_done.push_back(s + 8);
        pulse_start(1, 2, 2);
        tick();
        tick();
        bitwidth     = 4'd5;
        num_w_chunks = 8'd3;
        num_a_chunks = 8'd3;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        wait_idle();
`ifdef COORD_SCHED_PERF_EN
        chk("t6_perf_issue", int'(perf_issue_cnt), 4);
        chk("t6_perf_stall", int'(perf_stall_cnt), 0);
`endif
        repeat (3) tick();

        chk("sb_issues_left", exp_q.size(), 0);
        chk("sb_done_left", exp_done.size(), 0);
        chk("sb_cfg_left", exp_cfg.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
